// File: rtl/axi_rd_lite_bridge_if.sv
// Bus bundle for the AXI read burst to AXI-Lite single-beat bridge.
// Holds the upstream AR/R and downstream AR/R channels; the slave modport is the bridge's view.
interface axi_rd_lite_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic                  up_ar_valid;
  logic                  up_ar_ready;
  logic [ID_WIDTH-1:0]   up_ar_id;
  logic [ADDR_WIDTH-1:0] up_ar_addr;
  logic [7:0]            up_ar_len;
  logic [2:0]            up_ar_size;
  logic [1:0]            up_ar_burst;
  logic [2:0]            up_ar_prot;

  logic                  up_r_valid;
  logic                  up_r_ready;
  logic [ID_WIDTH-1:0]   up_r_id;
  logic [DATA_WIDTH-1:0] up_r_data;
  logic [1:0]            up_r_resp;
  logic                  up_r_last;

  logic                  dn_ar_valid;
  logic                  dn_ar_ready;
  logic [ADDR_WIDTH-1:0] dn_ar_addr;
  logic [2:0]            dn_ar_prot;

  logic                  dn_r_valid;
  logic                  dn_r_ready;
  logic [DATA_WIDTH-1:0] dn_r_data;
  logic [1:0]            dn_r_resp;

  modport slave (
    input  up_ar_valid,
    output up_ar_ready,
    input  up_ar_id,
    input  up_ar_addr,
    input  up_ar_len,
    input  up_ar_size,
    input  up_ar_burst,
    input  up_ar_prot,
    output up_r_valid,
    input  up_r_ready,
    output up_r_id,
    output up_r_data,
    output up_r_resp,
    output up_r_last,
    output dn_ar_valid,
    input  dn_ar_ready,
    output dn_ar_addr,
    output dn_ar_prot,
    input  dn_r_valid,
    output dn_r_ready,
    input  dn_r_data,
    input  dn_r_resp
  );

  modport master (
    output up_ar_valid,
    input  up_ar_ready,
    output up_ar_id,
    output up_ar_addr,
    output up_ar_len,
    output up_ar_size,
    output up_ar_burst,
    output up_ar_prot,
    input  up_r_valid,
    output up_r_ready,
    input  up_r_id,
    input  up_r_data,
    input  up_r_resp,
    input  up_r_last,
    input  dn_ar_valid,
    output dn_ar_ready,
    input  dn_ar_addr,
    input  dn_ar_prot,
    output dn_r_valid,
    input  dn_r_ready,
    output dn_r_data,
    output dn_r_resp
  );
endinterface

// File: rtl/axi_rd_lite_bridge.sv
// Splits each upstream AXI read burst into len+1 single-beat AXI-Lite reads, one at a time.
// Ports: clk, rst (sync, active-high), bus (slave modport: upstream AR/R in, downstream AR/R out).
module axi_rd_lite_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input logic                  clk,
  input logic                  rst,
  axi_rd_lite_bridge_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RESP,
    ERR
  } state_t;

  localparam logic [31:0] MAX_SIZE =
    32'($clog2(DATA_WIDTH / 8));
  localparam logic [ADDR_WIDTH-1:0] ONE =
    {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;

  logic                  up_ar_ready_q;
  logic                  dn_ar_valid_q;
  logic [ADDR_WIDTH-1:0] dn_ar_addr_q;
  logic [2:0]            dn_ar_prot_q;
  logic                  dn_r_ready_q;
  logic                  up_r_valid_q;
  logic [ID_WIDTH-1:0]   up_r_id_q;
  logic [DATA_WIDTH-1:0] up_r_data_q;
  logic [1:0]            up_r_resp_q;
  logic                  up_r_last_q;

  logic [ADDR_WIDTH-1:0] sz_bytes;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  wrap_len_ok;
  logic                  req_bad;

  assign bus.up_ar_ready = up_ar_ready_q;
  assign bus.dn_ar_valid = dn_ar_valid_q;
  assign bus.dn_ar_addr  = dn_ar_addr_q;
  assign bus.dn_ar_prot  = dn_ar_prot_q;
  assign bus.dn_r_ready  = dn_r_ready_q;
  assign bus.up_r_valid  = up_r_valid_q;
  assign bus.up_r_id     = up_r_id_q;
  assign bus.up_r_data   = up_r_data_q;
  assign bus.up_r_resp   = up_r_resp_q;
  assign bus.up_r_last   = up_r_last_q;

  // Next beat address. WRAP keeps the upper bits of the
  // current address above the window and increments inside it.
  always_comb begin
    sz_bytes  = ONE << size_q;
    aligned   = dn_ar_addr_q & ~(sz_bytes - ONE);
    incr      = aligned + sz_bytes;
    wrap_mask = '0;
    unique case (len_q)
      8'd1:    wrap_mask = (sz_bytes << 1) - ONE;
      8'd3:    wrap_mask = (sz_bytes << 2) - ONE;
      8'd7:    wrap_mask = (sz_bytes << 3) - ONE;
      default: wrap_mask = (sz_bytes << 4) - ONE;
    endcase
    unique case (burst_q)
      2'b00:   next_addr = dn_ar_addr_q;
      2'b10:   next_addr = (dn_ar_addr_q & ~wrap_mask)
                         | (incr & wrap_mask);
      default: next_addr = incr;
    endcase
  end

  // Requests we cannot serve are answered locally with SLVERR.
  always_comb begin
    wrap_len_ok = (bus.up_ar_len == 8'd1)
               || (bus.up_ar_len == 8'd3)
               || (bus.up_ar_len == 8'd7)
               || (bus.up_ar_len == 8'd15);
    req_bad = (bus.up_ar_burst == 2'b11)
           || (32'(bus.up_ar_size) > MAX_SIZE)
           || (bus.up_ar_burst == 2'b10 && !wrap_len_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      id_q          <= '0;
      len_q         <= '0;
      cnt           <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      up_ar_ready_q <= 1'b1;
      dn_ar_valid_q <= 1'b0;
      dn_ar_addr_q  <= '0;
      dn_ar_prot_q  <= '0;
      dn_r_ready_q  <= 1'b0;
      up_r_valid_q  <= 1'b0;
      up_r_id_q     <= '0;
      up_r_data_q   <= '0;
      up_r_resp_q   <= '0;
      up_r_last_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.up_ar_valid) begin
            id_q          <= bus.up_ar_id;
            len_q         <= bus.up_ar_len;
            size_q        <= bus.up_ar_size;
            burst_q       <= bus.up_ar_burst;
            dn_ar_addr_q  <= bus.up_ar_addr;
            dn_ar_prot_q  <= bus.up_ar_prot;
            cnt           <= '0;
            up_ar_ready_q <= 1'b0;
            if (req_bad) begin
              state        <= ERR;
              up_r_valid_q <= 1'b1;
              up_r_id_q    <= bus.up_ar_id;
              up_r_data_q  <= '0;
              up_r_resp_q  <= 2'b10;
              up_r_last_q  <= (bus.up_ar_len == 8'd0);
            end else begin
              state         <= ADDR;
              dn_ar_valid_q <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (bus.dn_ar_ready) begin
            dn_ar_valid_q <= 1'b0;
            dn_r_ready_q  <= 1'b1;
            state         <= DATA;
          end
        end
        DATA: begin
          if (bus.dn_r_valid) begin
            dn_r_ready_q <= 1'b0;
            up_r_valid_q <= 1'b1;
            up_r_id_q    <= id_q;
            up_r_data_q  <= bus.dn_r_data;
            up_r_resp_q  <= bus.dn_r_resp;
            up_r_last_q  <= (cnt == len_q);
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.up_r_ready) begin
            up_r_valid_q <= 1'b0;
            if (up_r_last_q) begin
              up_r_last_q   <= 1'b0;
              up_ar_ready_q <= 1'b1;
              state         <= IDLE;
            end else begin
              cnt           <= cnt + 8'd1;
              dn_ar_addr_q  <= next_addr;
              dn_ar_valid_q <= 1'b1;
              state         <= ADDR;
            end
          end
        end
        ERR: begin
          if (bus.up_r_ready) begin
            if (up_r_last_q) begin
              up_r_valid_q  <= 1'b0;
              up_r_last_q   <= 1'b0;
              up_ar_ready_q <= 1'b1;
              state         <= IDLE;
            end else begin
              cnt         <= cnt + 8'd1;
              up_r_last_q <= (cnt + 8'd1 == len_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_lite_bridge.sv
// Randomized bench for axi_rd_lite_bridge against a burst-level reference model.
// Drives upstream bursts, emulates a stalling AXI-Lite slave and a stalling R consumer.
module tb_axi_rd_lite_bridge;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_rd_lite_bridge_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) bus ();

  axi_rd_lite_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    int            cyc;
  } beat_t;

  int n_chk = 0;
  int n_fail = 0;

  bit stall;
  int err_beat;
  int dn_beats;
  int ar_viol;
  int r_viol;
  int cyc;

  logic [AW-1:0] dn_addr_q[$];
  logic [2:0]    dn_prot_q[$];
  logic [DW-1:0] dn_data_q[$];
  logic [1:0]    dn_resp_q[$];
  beat_t         up_q[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic bit exp_err(input int len,
                                 input int size,
                                 input int burst);
    if (burst == 3) return 1;
    if ((1 << size) > DW / 8) return 1;
    if (burst == 2 && !(len inside {1, 3, 7, 15}))
      return 1;
    return 0;
  endfunction

  function automatic logic [AW-1:0] exp_addr(
    input logic [AW-1:0] addr, input int len,
    input int size, input int burst, input int i);
    logic [AW-1:0] sb, al, wb, base;
    sb = AW'(1) << size;
    al = addr & ~(sb - 1);
    if (i == 0 || burst == 0) return addr;
    if (burst == 1) return al + AW'(i) * sb;
    wb = AW'(len + 1) * sb;
    base = addr & ~(wb - 1);
    return base + ((al - base + AW'(i) * sb) % wb);
  endfunction

  // AXI-Lite slave model with optional random stalls.
  bit rfire;
  bit pv, pfire;
  logic [AW-1:0] pa;
  logic [2:0] pp;
  int owed;
  initial begin
    bus.dn_ar_ready = 1'b0;
    bus.dn_r_valid = 1'b0;
    bus.dn_r_data = '0;
    bus.dn_r_resp = '0;
    rfire = 0; pv = 0; pfire = 0; owed = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.dn_ar_ready = 1'b0;
        bus.dn_r_valid = 1'b0;
        rfire = 0; pv = 0; pfire = 0; owed = 0;
      end else begin
        if (rfire) begin
          bus.dn_r_valid = 1'b0;
          rfire = 0;
        end
        if (!bus.dn_r_valid && owed > 0 &&
            (!stall || $urandom_range(0, 2) == 0)) begin
          bus.dn_r_valid = 1'b1;
          bus.dn_r_data = {$urandom, $urandom};
          if (err_beat < 0)
            bus.dn_r_resp = 2'($urandom_range(0, 3));
          else
            bus.dn_r_resp = (dn_beats == err_beat)
                            ? 2'b10 : 2'b00;
          dn_data_q.push_back(bus.dn_r_data);
          dn_resp_q.push_back(bus.dn_r_resp);
          dn_beats++;
          owed--;
        end
        if (bus.dn_r_valid && bus.dn_r_ready) rfire = 1;
        if (pv && !pfire && (!bus.dn_ar_valid ||
            bus.dn_ar_addr !== pa || bus.dn_ar_prot !== pp))
          ar_viol++;
        bus.dn_ar_ready = !stall || $urandom_range(0, 2) == 0;
        pfire = bus.dn_ar_valid && bus.dn_ar_ready;
        if (pfire) begin
          dn_addr_q.push_back(bus.dn_ar_addr);
          dn_prot_q.push_back(bus.dn_ar_prot);
          owed++;
        end
        pv = bus.dn_ar_valid;
        pa = bus.dn_ar_addr;
        pp = bus.dn_ar_prot;
      end
    end
  end

  // Upstream R consumer with optional random backpressure.
  bit upv, upf;
  logic [IW+DW+2:0] upp;
  initial begin
    bus.up_r_ready = 1'b0;
    upv = 0; upf = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        bus.up_r_ready = 1'b0;
        upv = 0; upf = 0;
      end else begin
        if (upv && !upf && (!bus.up_r_valid ||
            {bus.up_r_id, bus.up_r_data, bus.up_r_resp,
             bus.up_r_last} !== upp))
          r_viol++;
        bus.up_r_ready = !stall || $urandom_range(0, 2) == 0;
        upf = bus.up_r_valid && bus.up_r_ready;
        if (upf)
          up_q.push_back('{bus.up_r_id, bus.up_r_data,
                           bus.up_r_resp, bus.up_r_last, cyc});
        upv = bus.up_r_valid;
        upp = {bus.up_r_id, bus.up_r_data, bus.up_r_resp,
               bus.up_r_last};
      end
    end
  end

  task automatic clear_model();
    dn_addr_q.delete();
    dn_prot_q.delete();
    dn_data_q.delete();
    dn_resp_q.delete();
    up_q.delete();
    dn_beats = 0;
    ar_viol = 0;
    r_viol = 0;
  endtask

  task automatic send_ar(input logic [IW-1:0] id,
                         input logic [AW-1:0] addr,
                         input int len, input int size,
                         input int burst, input int prot,
                         input bit chk_lat);
    int t;
    bit err;
    err = exp_err(len, size, burst);
    @(negedge clk);
    bus.up_ar_id = id;
    bus.up_ar_addr = addr;
    bus.up_ar_len = 8'(len);
    bus.up_ar_size = 3'(size);
    bus.up_ar_burst = 2'(burst);
    bus.up_ar_prot = 3'(prot);
    bus.up_ar_valid = 1'b1;
    t = 0;
    while (!bus.up_ar_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ar_accept", bus.up_ar_ready, 1);
    @(negedge clk);
    bus.up_ar_valid = 1'b0;
    if (chk_lat) begin
      check("dn_ar_lat", bus.dn_ar_valid, !err);
      check("up_r_lat", bus.up_r_valid, err);
      check("ar_rdy_busy", bus.up_ar_ready, 0);
    end
  endtask

  task automatic run_burst(input logic [IW-1:0] id,
                           input logic [AW-1:0] addr,
                           input int len, input int size,
                           input int burst, input int prot,
                           input int eb, input bit chk_lat);
    int n, t;
    bit err;
    logic [DW-1:0] ed;
    logic [1:0] er;
    n = len + 1;
    err = exp_err(len, size, burst);
    clear_model();
    err_beat = eb;
    send_ar(id, addr, len, size, burst, prot, chk_lat);
    t = 0;
    while (up_q.size() < n && t < 40 * n + 100) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    check("beat_count", up_q.size(), n);
    check("dn_count", dn_addr_q.size(), err ? 0 : n);
    for (int i = 0; i < n && i < up_q.size(); i++) begin
      ed = '0;
      er = 2'b10;
      if (!err && i < dn_data_q.size()) begin
        ed = dn_data_q[i];
        er = dn_resp_q[i];
      end
      check($sformatf("id%0d", i), up_q[i].id, id);
      check($sformatf("data%0d", i), up_q[i].data, ed);
      check($sformatf("resp%0d", i), up_q[i].resp, er);
      check($sformatf("last%0d", i), up_q[i].last,
            i == len);
      if (!err && i < dn_addr_q.size()) begin
        check($sformatf("addr%0d", i), dn_addr_q[i],
              exp_addr(addr, len, size, burst, i));
        check($sformatf("prot%0d", i), dn_prot_q[i], prot);
      end
    end
    check("ar_stable", ar_viol, 0);
    check("r_stable", r_viol, 0);
    if (!stall && !err && n > 1 && up_q.size() > 1)
      check("tput", up_q[1].cyc - up_q[0].cyc, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, len, size, burst;
    rst = 1'b1;
    stall = 0;
    err_beat = 99;
    bus.up_ar_valid = 1'b0;
    bus.up_ar_id = '0;
    bus.up_ar_addr = '0;
    bus.up_ar_len = '0;
    bus.up_ar_size = '0;
    bus.up_ar_burst = '0;
    bus.up_ar_prot = '0;
    repeat (3) @(negedge clk);
    check("rst_dn_ar_valid", bus.dn_ar_valid, 0);
    check("rst_up_r_valid", bus.up_r_valid, 0);
    check("rst_dn_r_ready", bus.dn_r_ready, 0);
    check("rst_up_r_last", bus.up_r_last, 0);
    check("rst_up_r_data", bus.up_r_data, 0);
    check("rst_up_r_resp", bus.up_r_resp, 0);
    check("rst_up_r_id", bus.up_r_id, 0);
    check("rst_dn_ar_addr", bus.dn_ar_addr, 0);
    check("rst_dn_ar_prot", bus.dn_ar_prot, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ar_ready", bus.up_ar_ready, 1);

    run_burst(4'h5, 32'h1000, 3, 3, 1, 2, 99, 1);
    run_burst(4'h6, 32'h1018, 3, 3, 2, 1, 99, 1);
    run_burst(4'h7, 32'h2004, 2, 2, 0, 0, 99, 1);
    run_burst(4'h8, 32'h3003, 1, 2, 1, 5, 99, 1);
    run_burst(4'h9, 32'h4000, 1, 4, 1, 0, 99, 1);
    run_burst(4'ha, 32'h5000, 1, 3, 3, 0, 99, 1);
    run_burst(4'hb, 32'h6000, 2, 3, 2, 0, 99, 1);
    stall = 1;
    run_burst(4'hc, 32'h7000, 3, 3, 1, 3, 1, 0);
    stall = 0;
    run_burst(4'hd, 32'hffff_ff00, 255, 3, 1, 0, -1, 1);

    clear_model();
    err_beat = 99;
    send_ar(4'h3, 32'h8000, 7, 3, 1, 0, 0);
    t = 0;
    while (!(dn_addr_q.size() == 2 && bus.dn_r_ready)
           && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reach_data2", bus.dn_r_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_dn_ar_valid", bus.dn_ar_valid, 0);
    check("mid_up_r_valid", bus.up_r_valid, 0);
    check("mid_dn_r_ready", bus.dn_r_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    check("mid_ar_ready", bus.up_ar_ready, 1);
    repeat (10) @(negedge clk);
    check("mid_no_beats", up_q.size(), 0);
    check("mid_no_dn", dn_addr_q.size(), 0);
    run_burst(4'h2, 32'h9000, 3, 3, 1, 0, -1, 1);

    stall = 1;
    for (int k = 0; k < 40; k++) begin
      size = $urandom_range(0, 4);
      burst = $urandom_range(0, 3);
      len = $urandom_range(0, 15);
      if (burst == 2 && $urandom_range(0, 1) == 1)
        len = (2 << $urandom_range(0, 3)) - 1;
      run_burst(4'($urandom), $urandom, len, size, burst,
                $urandom_range(0, 7), -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
